multicycle_alu: RTL and testbench
=================================

// Module: multicycle_alu
//
// PURPOSE
//   Parametrised, registered ALU for the MIPS-based datapath. It extends the
//   16-bit combinational ALU opcode set with shifts, unsigned compare and an
//   iterative shift-add multiplier, all behind a start/busy/done handshake.
//   It sits between the register-file read ports and the writeback mux.
//   The control FSM stalls the pipeline while busy=1.
//
// PARAMETERS
//   WIDTH   16  operand/result width in bits (power of 2, >= 4)
//   SHW     4   shift-amount width = log2(WIDTH); must match WIDTH
//   MUL_EN  1   1: MUL implemented; 0: op 4'h8 decodes as undefined
//
// PORTS
//   clk     in   1       rising-edge clock
//   rst_n   in   1       asynchronous, active-low reset
//   start   in   1       request; sampled only while busy=0
//   op      in   4       opcode, captured with start
//   rs      in   WIDTH   operand A, captured with start
//   rt      in   WIDTH   operand B / shift amount (rt[SHW-1:0]), captured
//   rd      out  WIDTH   result (MUL: low half); held until next completion
//   rd_hi   out  WIDTH   MUL high half; 0 for all other ops
//   busy    out  1       high from the edge after start until done
//   done    out  1       one-cycle pulse; rd/rd_hi/flags valid in that cycle
//   zero    out  1       rd == 0 (replaces old bne = ~zero)
//   ov      out  1       signed overflow (ADD/SUB); rd_hi != 0 (MUL); else 0
//
// BEHAVIOUR
//   Opcodes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed), 5 SLTU,
//     3 SLL, 4 SRL, 9 SRA, 8 MUL (unsigned). All others are undefined:
//     rd=0, flags 0, normal 1-cycle done.
//   SLT is rd = {0.., sign(rs-rt) XOR ovf}, correct across overflow.
//     SLTU uses the borrow out of rs-rt.
//   Shifts: amount = rt[SHW-1:0]. SRA replicates rs[WIDTH-1].
//   FSM states: IDLE, MUL, DONE.
//     IDLE & start & op!=MUL: edge k captures and computes the result;
//       DONE in the cycle after edge k (latency 1); busy stays 0.
//     IDLE & start & op==MUL: edge 0 loads the multiplicand, multiplier
//       and cnt=0; state becomes MUL and busy=1.
//     MUL: one add/shift per edge and cnt++. At cnt==WIDTH-1 the final
//       product registers and the state goes to DONE. done is high
//       exactly WIDTH cycles after the start edge.
//     DONE: done=1, busy=0 for one cycle, then IDLE. A start in the DONE
//       cycle is accepted (back-to-back).
//   start while busy=1 is ignored and not queued. op/rs/rt changes during
//     MUL have no effect.
//   rd, rd_hi, zero and ov update only on the completion edge and hold
//     otherwise.
//   Reset (any time, including mid-MUL): immediate abort. State=IDLE,
//     rd=0, rd_hi=0, busy=0, done=0, zero=1, ov=0, cnt=0. No done is
//     issued for the aborted op.
//   All arithmetic is modulo 2^WIDTH. MUL product is 2*WIDTH bits, split
//     {rd_hi, rd}.
//
// STRUCTURE
//   alu_pkg: opcode localparams (OP_AND..OP_MUL) and FSM state encodings.
//     It is shared with the control-unit decoder.
//   Sub-module shift_add_multiplier (WIDTH): load/step/cnt, product regs.
//     Top level holds the FSM, the 1-cycle op mux, flags and output regs.
//
// TESTING (WIDTH=16)
//   ADD 0x7FFF+0x0001 -> done 1 cycle after start, rd=0x8000, ov=1, zero=0
//   SUB 5-5 -> rd=0, zero=1.
//     SLT 0x8000,0x0001 -> rd=1; SLTU same operands -> rd=0.
//   SLL 0x0001 by 15 -> 0x8000; SRL 0x8000 by 4 -> 0x0800;
//     SRA 0x8000 by 4 -> 0xF800.
//   MUL 0x1234*0x0100 -> done exactly 16 cycles after start, rd=0x3400,
//     rd_hi=0x0012, ov=1; busy=1 throughout; start pulsed at cycle 5 is
//     ignored and the result is unchanged.
//   rst_n low at cycle 8 of MUL -> busy=0, rd=0, zero=1 immediately, no
//     done. The next ADD 2+3 -> rd=5.
//   op=0xF -> rd=0, done pulse 1 cycle later. Back-to-back start in the
//     DONE cycle -> second result 1 cycle later.

Source files
------------

// File: rtl/multicycle_alu_pkg.sv
// multicycle_alu_pkg: opcode encodings and FSM states shared by the ALU and the control-unit decoder.
package multicycle_alu_pkg;
  localparam logic [3:0] OP_AND  = 4'h0;
  localparam logic [3:0] OP_OR   = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SLL  = 4'h3;
  localparam logic [3:0] OP_SRL  = 4'h4;
  localparam logic [3:0] OP_SLTU = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_SLT  = 4'h7;
  localparam logic [3:0] OP_MUL  = 4'h8;
  localparam logic [3:0] OP_SRA  = 4'h9;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} state_t;
endpackage

// File: rtl/multicycle_alu_if.sv
// multicycle_alu_if: start/busy/done request bus between the datapath and the ALU.
interface multicycle_alu_if #(parameter int WIDTH = 16);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] rs, rt, rd, rd_hi;
  logic             busy, done, zero, ov;
  modport master (output start, op, rs, rt, input rd, rd_hi, busy, done, zero, ov);
  modport slave  (input start, op, rs, rt, output rd, rd_hi, busy, done, zero, ov);
endinterface

// File: rtl/multicycle_alu_shift_add_multiplier.sv
// shift_add_multiplier: unsigned radix-2 shift-add multiplier, one multiplier bit per step.
module shift_add_multiplier #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   mcand_i,
  input  logic [WIDTH-1:0]   mplier_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] prod_o
);
  localparam int CW = $clog2(WIDTH);
  logic [WIDTH-1:0] mcand_q, hi_q, lo_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH:0]   sum;
  // prod_o is the product after the current step; lo_q starts as the multiplier and drains out
  assign sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_o = {sum, lo_q[WIDTH-1:1]};
  assign last_o = cnt_q == CW'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      mcand_q <= mcand_i;
      hi_q    <= '0;
      lo_q    <= mplier_i;
      cnt_q   <= '0;
    end else if (step_i) begin
      {hi_q, lo_q} <= prod_o;
      cnt_q        <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: registered ALU with 1-cycle ops and an iterative MUL behind start/busy/done.
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int SHW    = 4,
  parameter int MUL_EN = 1
) (
  input logic              clk,
  input logic              rst_n,
  multicycle_alu_if.slave  bus
);
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   rd_q, rd_d, hi_q, hi_d, alu, sum;
  logic               zero_q, zero_d, ov_q, ov_d, alu_ov;
  logic [WIDTH:0]     diff;
  logic               add_ov, sub_ov, accept, is_mul, mul_last, fin_mul, fin_op;
  logic [2*WIDTH-1:0] prod;
  logic [SHW-1:0]     sh;
  assign accept  = bus.start && state_q != ST_MUL;
  assign is_mul  = MUL_EN != 0 && bus.op == OP_MUL;
  assign fin_mul = state_q == ST_MUL && mul_last;
  assign fin_op  = accept && !is_mul;
  shift_add_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept && is_mul),
    .step_i   (state_q == ST_MUL),
    .mcand_i  (bus.rs),
    .mplier_i (bus.rt),
    .last_o   (mul_last),
    .prod_o   (prod)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rd_q    <= '0;
      hi_q    <= '0;
      zero_q  <= 1'b1;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      hi_q    <= hi_d;
      zero_q  <= zero_d;
      ov_q    <= ov_d;
    end
  end
  always_comb begin
    state_d = state_q == ST_MUL ? (mul_last ? ST_DONE : ST_MUL)
            : accept ? (is_mul ? ST_MUL : ST_DONE) : ST_IDLE;
  end
  // SLT uses sign XOR overflow so it stays correct when rs-rt wraps
  assign sum    = bus.rs + bus.rt;
  assign diff   = {1'b0, bus.rs} - {1'b0, bus.rt};
  assign add_ov = bus.rs[WIDTH-1] == bus.rt[WIDTH-1] && sum[WIDTH-1] != bus.rs[WIDTH-1];
  assign sub_ov = bus.rs[WIDTH-1] != bus.rt[WIDTH-1] && diff[WIDTH-1] != bus.rs[WIDTH-1];
  assign sh     = bus.rt[SHW-1:0];
  always_comb begin
    alu    = '0;
    alu_ov = 1'b0;
    case (bus.op)
      OP_AND:  alu = bus.rs & bus.rt;
      OP_OR:   alu = bus.rs | bus.rt;
      OP_ADD:  begin alu = sum; alu_ov = add_ov; end
      OP_SUB:  begin alu = diff[WIDTH-1:0]; alu_ov = sub_ov; end
      OP_SLT:  alu = WIDTH'(diff[WIDTH-1] ^ sub_ov);
      OP_SLTU: alu = WIDTH'(diff[WIDTH]);
      OP_SLL:  alu = bus.rs << sh;
      OP_SRL:  alu = bus.rs >> sh;
      OP_SRA:  alu = WIDTH'($signed(bus.rs) >>> sh);
      default: alu = '0;
    endcase
  end
  always_comb begin
    rd_d   = fin_mul ? prod[WIDTH-1:0] : fin_op ? alu : rd_q;
    hi_d   = fin_mul ? prod[2*WIDTH-1:WIDTH] : fin_op ? '0 : hi_q;
    zero_d = fin_mul ? prod[WIDTH-1:0] == '0 : fin_op ? alu == '0 : zero_q;
    ov_d   = fin_mul ? prod[2*WIDTH-1:WIDTH] != '0 : fin_op ? alu_ov : ov_q;
  end
  always_comb begin
    bus.busy  = state_q == ST_MUL;
    bus.done  = state_q == ST_DONE;
    bus.rd    = rd_q;
    bus.rd_hi = hi_q;
    bus.zero  = zero_q;
    bus.ov    = ov_q;
  end
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed checks of 1-cycle ops, MUL timing, mid-MUL reset and back-to-back starts.
module tb_multicycle_alu;
  import multicycle_alu_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  multicycle_alu_if #(.WIDTH(16)) bus ();
  multicycle_alu #(.WIDTH(16), .SHW(4), .MUL_EN(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic go(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs    = a;
    bus.rt    = b;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 1'b0;
    bus.op    = 4'h0;
    bus.rs    = '0;
    bus.rt    = '0;
    rst_n     = 1'b1;
    #2 rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd", bus.rd, 0);
    chk("rst_hi", bus.rd_hi, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_ov", bus.ov, 0);
    rst_n = 1'b1;
    go(OP_ADD, 16'h7FFF, 16'h0001);
    chk("add_done", bus.done, 1);
    chk("add_busy", bus.busy, 0);
    chk("add_rd", bus.rd, 16'h8000);
    chk("add_ov", bus.ov, 1);
    chk("add_zero", bus.zero, 0);
    chk("add_hi", bus.rd_hi, 0);
    @(negedge clk);
    chk("add_done_drop", bus.done, 0);
    chk("add_rd_hold", bus.rd, 16'h8000);
    go(OP_SUB, 16'd5, 16'd5);
    chk("sub_rd", bus.rd, 0);
    chk("sub_zero", bus.zero, 1);
    chk("sub_ov", bus.ov, 0);
    go(OP_SLT, 16'h8000, 16'h0001);
    chk("slt_rd", bus.rd, 1);
    chk("slt_ov", bus.ov, 0);
    go(OP_SLTU, 16'h8000, 16'h0001);
    chk("sltu_rd", bus.rd, 0);
    go(OP_SLL, 16'h0001, 16'd15);
    chk("sll_rd", bus.rd, 16'h8000);
    go(OP_SRL, 16'h8000, 16'd4);
    chk("srl_rd", bus.rd, 16'h0800);
    go(OP_SRA, 16'h8000, 16'h0014);
    chk("sra_rd", bus.rd, 16'hF800);
    go(OP_AND, 16'hF0F0, 16'h3C3C);
    chk("and_rd", bus.rd, 16'h3030);
    go(OP_OR, 16'hF0F0, 16'h3C3C);
    chk("or_rd", bus.rd, 16'hFCFC);
    go(OP_MUL, 16'h1234, 16'h0100);
    bus.op = OP_AND;
    bus.rs = 16'hFFFF;
    bus.rt = 16'hFFFF;
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("mul_busy_%0d", j), {bus.busy, bus.done}, 2'b10);
      if (j == 10) chk("mul_rd_hold", bus.rd, 16'hFCFC);
      if (j == 5) begin
        bus.start = 1'b1;
        bus.op    = OP_ADD;
      end
      if (j == 6) bus.start = 1'b0;
      @(negedge clk);
    end
    chk("mul_done", bus.done, 1);
    chk("mul_busy_end", bus.busy, 0);
    chk("mul_rd", bus.rd, 16'h3400);
    chk("mul_hi", bus.rd_hi, 16'h0012);
    chk("mul_ov", bus.ov, 1);
    chk("mul_zero", bus.zero, 0);
    @(negedge clk);
    chk("mul_idle", {bus.busy, bus.done}, 2'b00);
    go(OP_MUL, 16'h1234, 16'h0100);
    repeat (8) @(negedge clk);
    chk("abort_pre_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_rd", bus.rd, 0);
    chk("abort_hi", bus.rd_hi, 0);
    chk("abort_zero", bus.zero, 1);
    chk("abort_done", bus.done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      chk($sformatf("abort_nodone_%0d", j), {bus.busy, bus.done}, 2'b00);
    end
    go(OP_ADD, 16'd2, 16'd3);
    chk("post_add_done", bus.done, 1);
    chk("post_add_rd", bus.rd, 16'd5);
    go(4'hF, 16'h1234, 16'h5678);
    chk("undef_done", bus.done, 1);
    chk("undef_rd", bus.rd, 0);
    chk("undef_hi", bus.rd_hi, 0);
    chk("undef_ov", bus.ov, 0);
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.rs    = 16'd7;
    bus.rt    = 16'd9;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b2b_done", bus.done, 1);
    chk("b2b_rd", bus.rd, 16'd16);
    @(negedge clk);
    chk("b2b_idle", bus.done, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
